psram_init_seq: RTL and testbench

Power-up and re-initialisation sequencer for the QSPI PSRAM. Sits between the Wishbone PSRAM controller and the chip pins, and holds the controller off the bus after reset. It waits out the device power-up time and then issues Reset-Enable (0x66), Reset (0x99) and Enter-QPI (0x35) in single-bit SPI mode. After that it hands the pins and the Wishbone strobe path to the controller.

---
 rtl/psram_pkg.sv | 22 ++
 rtl/psram_spi_byte_tx.sv | 38 +++
 rtl/psram_init_seq.sv | 106 ++++++++++
 tb/tb_psram_init_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: shared PSRAM opcodes, init-sequencer state encoding and opcode lookup.
package psram_pkg;

    localparam logic [7:0] PSRAM_CMD_RSTEN = 8'h66;
    localparam logic [7:0] PSRAM_CMD_RST   = 8'h99;
    localparam logic [7:0] PSRAM_CMD_QPI   = 8'h35;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_CE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } psram_init_state_t;

    function automatic logic [7:0] psram_opcode(input logic [1:0] cmd);
        return cmd == 2'd0 ? PSRAM_CMD_RSTEN :
               cmd == 2'd1 ? PSRAM_CMD_RST   : PSRAM_CMD_QPI;
    endfunction

endpackage

// File: rtl/psram_spi_byte_tx.sv
// psram_spi_byte_tx: single-bit SPI byte shifter, 16 clk cycles per byte, MSB first.
module psram_spi_byte_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_sck,
    output logic       o_so,
    output logic       o_busy,
    output logic       o_done
);

    logic       r_busy;
    logic [3:0] r_p;
    logic [7:0] r_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_p    <= '0;
            r_byte <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_p    <= '0;
            r_byte <= i_byte;
        end else if (r_busy) begin
            r_p    <= r_p + 4'd1;
            r_busy <= r_p != 4'hF;
        end
    end

    // bit index advances on even phases, so data moves only while sck is low
    assign o_sck  = r_busy & r_p[0];
    assign o_so   = r_busy & r_byte[3'd7 - r_p[3:1]];
    assign o_busy = r_busy;
    assign o_done = r_busy & (r_p == 4'hF);

endmodule

// File: rtl/psram_init_seq.sv
// psram_init_seq: PSRAM power-up wait plus RSTEN/RST/QPI command sequence, then
// hands the pads and the Wishbone strobe path to the controller.
module psram_init_seq
    import psram_pkg::*;
#(
    parameter int PWRUP_CYCLES = 15000,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reinit,
    input  logic       cyc_in,
    input  logic       stb_in,
    output logic       cyc_out,
    output logic       stb_out,
    input  logic       ctrl_sck,
    input  logic       ctrl_ce_n,
    input  logic [3:0] ctrl_dout,
    input  logic [3:0] ctrl_douten,
    output logic       sck,
    output logic       ce_n,
    output logic [3:0] dout,
    output logic [3:0] douten,
    output logic       init_done
);

    localparam int CW = $clog2(PWRUP_CYCLES + GAP_CYCLES + 1);

    psram_init_state_t r_state, w_next;
    logic [CW-1:0]     r_cnt, w_cnt_next;
    logic [1:0]        r_cmd, w_cmd_next;
    logic              r_pend, w_pend_next;
    logic              w_tx_sck, w_tx_so, w_tx_busy, w_tx_done;
    logic              w_done, w_active;

    psram_spi_byte_tx u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_state == ST_CE),
        .i_byte  (psram_opcode(r_cmd)),
        .o_sck   (w_tx_sck),
        .o_so    (w_tx_so),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PWRUP;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_cmd   <= w_cmd_next;
            r_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_cmd_next  = r_cmd;
        w_pend_next = r_pend;
        case (r_state)
            ST_PWRUP: begin
                w_next     = r_cnt == CW'(PWRUP_CYCLES - 1) ? ST_CE : ST_PWRUP;
                w_cnt_next = r_cnt == CW'(PWRUP_CYCLES - 1) ? '0 : r_cnt + 1'b1;
            end
            ST_CE:    w_next = ST_SHIFT;
            ST_SHIFT: w_next = w_tx_done ? ST_HOLD : ST_SHIFT;
            ST_HOLD:  w_next = ST_GAP;
            ST_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_cnt_next = '0;
                    w_next     = r_cmd == 2'd2 ? ST_DONE : ST_CE;
                    w_cmd_next = r_cmd == 2'd2 ? r_cmd : r_cmd + 2'd1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                // re-run waits for an idle bus so no transfer is cut mid-cycle
                w_pend_next = r_pend | reinit;
                if (r_pend && !cyc_in) begin
                    w_next      = ST_CE;
                    w_cmd_next  = '0;
                    w_pend_next = 1'b0;
                end
            end
            default:  w_next = ST_PWRUP;
        endcase
    end

    assign w_done    = r_state == ST_DONE;
    assign w_active  = r_state == ST_CE || r_state == ST_SHIFT || r_state == ST_HOLD;
    assign init_done = w_done;
    assign cyc_out   = w_done & cyc_in;
    assign stb_out   = w_done & stb_in;
    assign sck       = w_done ? ctrl_sck    : w_tx_sck;
    assign ce_n      = w_done ? ctrl_ce_n   : !w_active;
    assign dout      = w_done ? ctrl_dout   : {3'b000, w_tx_so};
    assign douten    = w_done ? ctrl_douten : {3'b000, w_tx_busy};

endmodule

// File: tb/tb_psram_init_seq.sv
// tb_psram_init_seq: directed bench decoding SPI bytes off the pads and checking
// timing, Wishbone gating, pad bypass, reinit handshake and mid-shift reset.
module tb_psram_init_seq;

    localparam int P = 20;
    localparam int G = 4;

    logic       clk = 1'b0, rst_n = 1'b1, reinit = 1'b0, cyc_in = 1'b0, stb_in = 1'b0;
    logic       ctrl_sck = 1'b0, ctrl_ce_n = 1'b0;
    logic [3:0] ctrl_dout = 4'hA, ctrl_douten = 4'hF;
    logic       cyc_out, stb_out, sck, ce_n, init_done;
    logic [3:0] dout, douten;

    int pass_cnt = 0, chk_cnt = 0;
    bit tog = 1'b1;

    psram_init_seq #(.PWRUP_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .cyc_in(cyc_in), .stb_in(stb_in),
        .cyc_out(cyc_out), .stb_out(stb_out), .ctrl_sck(ctrl_sck), .ctrl_ce_n(ctrl_ce_n),
        .ctrl_dout(ctrl_dout), .ctrl_douten(ctrl_douten), .sck(sck), .ce_n(ce_n),
        .dout(dout), .douten(douten), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tog) #2 ctrl_sck = ~ctrl_sck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // pad monitor: decodes bytes on dout[0] at sck rises inside ce_n-low windows
    logic [7:0] bq[$];
    int         nbq[$];
    logic [7:0] sh = '0;
    int         nbits = 0, gap = 0, min_gap = 1000, leak = 0;
    bit         in_win = 0, seen = 0;
    logic       p_sck = 1'b0, p_ce_n = 1'b1;

    always @(negedge clk) begin
        if (!rst_n || init_done) begin
            in_win = 0;
            nbits  = 0;
            gap    = 0;
        end else begin
            if (cyc_out || stb_out || douten[3:1] != 3'b0 || (ce_n && sck)) leak++;
            if (p_ce_n && !ce_n) begin
                if (seen && gap < min_gap) min_gap = gap;
                in_win = 1;
                nbits  = 0;
                sh     = '0;
            end
            if (!p_ce_n && ce_n && in_win) begin
                bq.push_back(sh);
                nbq.push_back(nbits);
                in_win = 0;
                seen   = 1;
                gap    = 0;
            end
            if (ce_n) gap++;
            if (!ce_n && !p_sck && sck && in_win) begin
                sh = {sh[6:0], dout[0]};
                nbits++;
            end
        end
        p_sck  = sck;
        p_ce_n = ce_n;
    end

    task automatic clear_mon();
        bq.delete();
        nbq.delete();
        seen    = 0;
        min_gap = 1000;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done) break;
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] exp [3] = '{8'h66, 8'h99, 8'h35};
        check({tag, "_nbytes"}, bq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_byte"}, i < bq.size() ? bq[i] : 8'hxx, exp[i]);
            check({tag, "_bits"}, i < nbq.size() ? nbq[i] : -1, 8);
        end
        check({tag, "_gap"}, min_gap, G);
    endtask

    initial begin
        int n;
        int bad;
        bit found;
        #1 rst_n = 1'b0;
        #1;
        check("rst_sck", sck, 0);
        check("rst_ce_n", ce_n, 1);
        check("rst_dout", dout, 0);
        check("rst_douten", douten, 0);
        check("rst_init_done", init_done, 0);
        check("rst_cyc_out", cyc_out, 0);
        check("rst_stb_out", stb_out, 0);

        @(negedge clk);
        cyc_in = 1'b1;
        stb_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(n);
        check("pwrup_latency", n, P + 3 * (18 + G));
        check("pre_done_leak", leak, 0);
        check_bytes("init");
        check("done_cyc_out", cyc_out, 1);
        check("done_stb_out", stb_out, 1);

        tog       = 1'b0;
        ctrl_sck  = 1'b1;
        ctrl_ce_n = 1'b0;
        ctrl_dout = 4'hA;
        ctrl_douten = 4'hF;
        #1;
        check("byp_sck", sck, 1);
        check("byp_ce_n", ce_n, 0);
        check("byp_dout", dout, 4'hA);
        check("byp_douten", douten, 4'hF);
        ctrl_dout = 4'h5;
        #1;
        check("byp_dout_comb", dout, 4'h5);
        cyc_in = 1'b0;
        #1;
        check("byp_cyc_follow", cyc_out, 0);
        cyc_in = 1'b1;

        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!init_done || douten != 4'hF || dout != 4'h5) bad++;
        end
        check("reinit_hold_bus", bad, 0);
        ctrl_ce_n = 1'b1;
        ctrl_sck  = 1'b0;
        clear_mon();
        cyc_in = 1'b0;
        stb_in = 1'b0;
        @(posedge clk);
        #1;
        check("reinit_drop", init_done, 0);
        wait_done(n);
        check("reinit_latency", n, 3 * (18 + G));
        check_bytes("reinit");

        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        clear_mon();
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (bq.size() == 1 && nbits == 5 && !ce_n) begin
                found = 1;
                break;
            end
        end
        check("midshift_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check("midshift_ce_n", ce_n, 1);
        check("midshift_douten", douten, 0);
        check("midshift_init_done", init_done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_mon();
        wait_done(n);
        check("restart_latency", n, P + 3 * (18 + G));
        check_bytes("restart");
        check("final_leak", leak, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
